// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scanner
//  Description : N-digit multiplexed seven-segment driver with prescaler,
//                double-buffered data, LZ blanking, blink and brightness PWM.
//  Revision    : 1.0  initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dot_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    bi,
    input  logic                    hex_mode,
    input  logic                    lzb_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   digs,
    output logic [7:0]              segs,
    output logic                    frame_done
);

    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_MAX  = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [31:0]        c_PWM_STEP = 32'(SCAN_DIV / 16);

    generate
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seven_seg_scanner: NUM_DIGITS must be 2..8");
        end
        if (SCAN_DIV < 16 || (SCAN_DIV % 16) != 0) begin : g_bad_div
            $error("seven_seg_scanner: SCAN_DIV must be a multiple of 16");
        end
        if (BLINK_FRAMES < 1) begin : g_bad_blink
            $error("seven_seg_scanner: BLINK_FRAMES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]      r_cnt_q,          w_cnt_d;
    logic [c_IDX_W-1:0]      r_idx_q,          w_idx_d;
    logic [4*NUM_DIGITS-1:0] r_shadow_bcd_q,   w_shadow_bcd_d;
    logic [NUM_DIGITS-1:0]   r_shadow_dot_q,   w_shadow_dot_d;
    logic [NUM_DIGITS-1:0]   r_shadow_blink_q, w_shadow_blink_d;
    logic [4*NUM_DIGITS-1:0] r_active_bcd_q,   w_active_bcd_d;
    logic [NUM_DIGITS-1:0]   r_active_dot_q,   w_active_dot_d;
    logic [NUM_DIGITS-1:0]   r_active_blink_q, w_active_blink_d;
    logic [c_FRM_W-1:0]      r_frm_cnt_q,      w_frm_cnt_d;
    logic                    r_blink_ph_q,     w_blink_ph_d;
    logic [NUM_DIGITS-1:0]   r_digs_q,         w_digs_d;
    logic [7:0]              r_segs_q,         w_segs_d;
    logic                    r_frame_done_q,   w_frame_done_d;

    logic                    w_tick;
    logic                    w_wrap;
    logic [31:0]             w_on_limit;
    logic [3:0]              w_nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz;
    logic [3:0]              w_nib;
    logic [6:0]              w_glyph;

    function automatic logic [6:0] f_glyph(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        g = 7'b0000000;
        case (v)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1111011;
            4'hA: g = hex ? 7'b1110111 : 7'b0000000;
            4'hB: g = hex ? 7'b0011111 : 7'b0000000;
            4'hC: g = hex ? 7'b1001110 : 7'b0000000;
            4'hD: g = hex ? 7'b0111101 : 7'b0000000;
            4'hE: g = hex ? 7'b1001111 : 7'b0000000;
            default: g = hex ? 7'b1000111 : 7'b0000000;
        endcase
        return g;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble are 0.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_nib_arr[gi] = r_active_bcd_q[4*gi +: 4];
            if (gi == 0) begin : g_lz_units
                assign w_lz[gi] = 1'b0;
            end else begin : g_lz_upper
                assign w_lz[gi] = (r_active_bcd_q[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign w_tick     = (r_cnt_q == c_CNT_MAX);
    assign w_wrap     = w_tick && (r_idx_q == c_IDX_MAX);
    assign w_on_limit = (32'(brightness) + 32'd1) * c_PWM_STEP;
    assign w_nib      = w_nib_arr[r_idx_q];
    assign w_glyph    = f_glyph(w_nib, hex_mode);

    always_comb begin
        w_cnt_d          = w_tick ? '0 : r_cnt_q + 1'b1;
        w_idx_d          = r_idx_q;
        w_shadow_bcd_d   = r_shadow_bcd_q;
        w_shadow_dot_d   = r_shadow_dot_q;
        w_shadow_blink_d = r_shadow_blink_q;
        w_active_bcd_d   = r_active_bcd_q;
        w_active_dot_d   = r_active_dot_q;
        w_active_blink_d = r_active_blink_q;
        w_frm_cnt_d      = r_frm_cnt_q;
        w_blink_ph_d     = r_blink_ph_q;

        if (w_tick) begin
            w_idx_d = (r_idx_q == c_IDX_MAX) ? '0 : r_idx_q + 1'b1;
        end

        if (load) begin
            w_shadow_bcd_d   = bcd_in;
            w_shadow_dot_d   = dot_in;
            w_shadow_blink_d = blink_in;
        end

        // Active data only changes at a frame boundary; a coincident load bypasses the shadow.
        if (w_wrap) begin
            w_active_bcd_d   = load ? bcd_in   : r_shadow_bcd_q;
            w_active_dot_d   = load ? dot_in   : r_shadow_dot_q;
            w_active_blink_d = load ? blink_in : r_shadow_blink_q;
            if (r_frm_cnt_q == c_FRM_MAX) begin
                w_frm_cnt_d  = '0;
                w_blink_ph_d = ~r_blink_ph_q;
            end else begin
                w_frm_cnt_d  = r_frm_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_digs_d = '0;
        if (32'(r_cnt_q) < w_on_limit) begin
            w_digs_d = NUM_DIGITS'(1) << r_idx_q;
        end

        w_segs_d[6:0] = (lzb_en && w_lz[r_idx_q]) ? 7'b0000000 : w_glyph;
        w_segs_d[7]   = r_active_dot_q[r_idx_q];
        if (bi || (r_blink_ph_q && r_active_blink_q[r_idx_q])) begin
            w_segs_d = 8'h00;
        end

        w_frame_done_d = w_wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_q          <= '0;
            r_idx_q          <= '0;
            r_shadow_bcd_q   <= '0;
            r_shadow_dot_q   <= '0;
            r_shadow_blink_q <= '0;
            r_active_bcd_q   <= '0;
            r_active_dot_q   <= '0;
            r_active_blink_q <= '0;
            r_frm_cnt_q      <= '0;
            r_blink_ph_q     <= 1'b0;
            r_digs_q         <= '0;
            r_segs_q         <= '0;
            r_frame_done_q   <= 1'b0;
        end else begin
            r_cnt_q          <= w_cnt_d;
            r_idx_q          <= w_idx_d;
            r_shadow_bcd_q   <= w_shadow_bcd_d;
            r_shadow_dot_q   <= w_shadow_dot_d;
            r_shadow_blink_q <= w_shadow_blink_d;
            r_active_bcd_q   <= w_active_bcd_d;
            r_active_dot_q   <= w_active_dot_d;
            r_active_blink_q <= w_active_blink_d;
            r_frm_cnt_q      <= w_frm_cnt_d;
            r_blink_ph_q     <= w_blink_ph_d;
            r_digs_q         <= w_digs_d;
            r_segs_q         <= w_segs_d;
            r_frame_done_q   <= w_frame_done_d;
        end
    end

    assign digs       = r_digs_q;
    assign segs       = r_segs_q;
    assign frame_done = r_frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scanner
//  Description : Self-checking bench for seven_seg_scanner (4 digits, 16-clk
//                slots, 2-frame blink) against a cycle-number reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int SD = 16;
    localparam int BF = 2;
    localparam int F  = N * SD;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [15:0]   bcd_in;
    logic [3:0]    dot_in;
    logic [3:0]    blink_in;
    logic          bi;
    logic          hex_mode;
    logic          lzb_en;
    logic [3:0]    brightness;
    logic [3:0]    digs;
    logic [7:0]    segs;
    logic          frame_done;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .bcd_in     (bcd_in),
        .dot_in     (dot_in),
        .blink_in   (blink_in),
        .bi         (bi),
        .hex_mode   (hex_mode),
        .lzb_en     (lzb_en),
        .brightness (brightness),
        .digs       (digs),
        .segs       (segs),
        .frame_done (frame_done)
    );

    typedef struct {
        int unsigned cyc;
        logic [15:0] bcd;
        logic [3:0]  dot;
        logic [3:0]  blk;
    } load_t;

    load_t       loads[$];
    int unsigned k;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Data shown during frame f: the last load issued no later than the final
    // cycle of frame f-1 (zero before any frame boundary).
    task automatic active_for(input int unsigned f, output logic [15:0] b,
                              output logic [3:0] d, output logic [3:0] bl);
        b = '0; d = '0; bl = '0;
        if (f > 0) begin
            foreach (loads[i]) begin
                if (loads[i].cyc <= f * F - 1) begin
                    b = loads[i].bcd; d = loads[i].dot; bl = loads[i].blk;
                end
            end
        end
    endtask

    task automatic check_cycle();
        int unsigned f, cnt, idx;
        logic [15:0] b;
        logic [3:0]  d, bl, nib, e_digs;
        logic [6:0]  g;
        logic [7:0]  e_segs;
        logic        e_fd;
        f   = k / F;
        cnt = k % SD;
        idx = (k / SD) % N;
        active_for(f, b, d, bl);
        nib = b[idx*4 +: 4];
        g   = (nib >= 4'd10 && !hex_mode) ? 7'b0 : glyph_tab[nib];
        if (lzb_en && idx >= 1 && (b >> (4 * idx)) == 16'd0) g = 7'b0;
        e_segs = {d[idx], g};
        if (bi || (((f / BF) % 2) == 1 && bl[idx])) e_segs = 8'h00;
        e_digs = (cnt < (int'(brightness) + 1) * (SD / 16)) ? 4'(1 << idx) : 4'b0;
        e_fd   = ((k % F) == F - 1);

        n_tests++;
        assert (digs === e_digs) else begin
            n_fail++;
            $error("FAIL digs k=%0d observed=%b expected=%b", k, digs, e_digs);
        end
        n_tests++;
        assert (segs === e_segs) else begin
            n_fail++;
            $error("FAIL segs k=%0d observed=%b expected=%b", k, segs, e_segs);
        end
        n_tests++;
        assert (frame_done === e_fd) else begin
            n_fail++;
            $error("FAIL frame_done k=%0d observed=%b expected=%b", k, frame_done, e_fd);
        end
    endtask

    task automatic step();
        if (load) loads.push_back('{k, bcd_in, dot_in, blink_in});
        @(posedge clk);
        #1;
        check_cycle();
        k++;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_until(input int unsigned phase);
        while ((k % F) != phase) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        assert (digs === 4'b0) else begin
            n_fail++; $error("FAIL reset_digs observed=%b expected=0000", digs);
        end
        n_tests++;
        assert (segs === 8'h00) else begin
            n_fail++; $error("FAIL reset_segs observed=%b expected=00000000", segs);
        end
        n_tests++;
        assert (frame_done === 1'b0) else begin
            n_fail++; $error("FAIL reset_frame_done observed=%b expected=0", frame_done);
        end
        reset = 1'b0;
        k = 0;
        loads.delete();
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] bl);
        load = 1'b1; bcd_in = b; dot_in = d; blink_in = bl;
        step();
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; bcd_in = '0; dot_in = '0; blink_in = '0;
        bi = 1'b0; hex_mode = 1'b0; lzb_en = 1'b0; brightness = 4'd15;
        k = 0;
        do_reset();

        // Basic scan of 1234 at full brightness
        do_load(16'h1234, 4'b0000, 4'b0000);
        run(3 * F);

        // Hex value with leading-zero blanking, hex off then on
        lzb_en = 1'b1;
        do_load(16'h00A5, 4'b0100, 4'b0000);
        run(2 * F);
        hex_mode = 1'b1;
        run(2 * F);

        // Tear-free loading: mid-frame load waits for the frame boundary
        lzb_en = 1'b0; hex_mode = 1'b0;
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(F);
        run_until(SD + 5);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run(2 * F);
        run_until(F - 1);
        do_load(16'h3333, 4'b1111, 4'b0000);
        run(F);

        // Brightness PWM
        brightness = 4'd3;
        run(F);
        brightness = 4'd0;
        run(F);
        brightness = 4'd15;

        // Blink on digit 0
        do_load(16'h5678, 4'b0001, 4'b0001);
        run(8 * F);

        // Blanking input mid-frame
        run_until(2 * SD + 3);
        bi = 1'b1;
        run(20);
        bi = 1'b0;
        run(F);

        // Reset mid-slot clears active data and restarts at digit 0
        run_until(SD + 7);
        do_reset();
        run(2 * F);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ((i % 50) == 0) begin
                bi         = ($urandom_range(0, 3) == 0);
                hex_mode   = 1'($urandom_range(0, 1));
                lzb_en     = 1'($urandom_range(0, 1));
                brightness = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 39) == 0) begin
                load     = 1'b1;
                bcd_in   = 16'($urandom & ((32'd1 << (4 * $urandom_range(0, 4))) - 32'd1));
                dot_in   = 4'($urandom);
                blink_in = 4'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
